// File: rtl/piso_pkg.sv
// Shared constants and helpers for the piso_shift serializer.
package piso_pkg;

   localparam int unsigned PISO_DEFAULT_WIDTH = 8;

   // Bit-reverse a default-width word; maps MSB-first order onto LSB-first order.
   function automatic logic [PISO_DEFAULT_WIDTH-1:0] reverse_bits(
      input logic [PISO_DEFAULT_WIDTH-1:0] word
   );
      logic [PISO_DEFAULT_WIDTH-1:0] rev;
      rev = '0;
      for (int unsigned i = 0; i < PISO_DEFAULT_WIDTH; i++) begin
         rev[i] = word[PISO_DEFAULT_WIDTH-1-i];
      end
      return rev;
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in, serial-out shift register, MSB first by default.
// Define PISO_LSB_FIRST_EN to shift right and emit the word LSB first.
module piso_shift
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_in,
   output logic             serial_out
);

   logic [WIDTH-1:0] shift_q;

   // Priority reset > load > shift; shifting is free-running with zero fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '0;
      end else if (load) begin
         shift_q <= parallel_in;
      end else begin
`ifdef PISO_LSB_FIRST_EN
         shift_q <= {1'b0, shift_q[WIDTH-1:1]};
`else
         shift_q <= {shift_q[WIDTH-2:0], 1'b0};
`endif
      end
   end

`ifdef PISO_LSB_FIRST_EN
   assign serial_out = shift_q[0];
`else
   assign serial_out = shift_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_shift.sv
// Directed self-checking bench for piso_shift (WIDTH=8), both bit orders.
module tb_piso_shift;
   import piso_pkg::*;

   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic         load;
   logic [W-1:0] parallel_in;
   logic         serial_out;

   int unsigned errors = 0;
   int unsigned checks = 0;

   piso_shift #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .parallel_in(parallel_in),
      .serial_out (serial_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected i-th emitted bit (i=0 is the bit visible right after the load edge).
   function automatic logic exp_bit(input logic [W-1:0] word, input int unsigned i);
      logic [W-1:0] ord;
`ifdef PISO_LSB_FIRST_EN
      ord = reverse_bits(word);
`else
      ord = word;
`endif
      if (i >= W) return 1'b0;
      return ord[W-1-i];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b0; parallel_in = 8'hA5;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (serial_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_out edge%0d: got %b want 0", k, serial_out);
         end
         checks++;
         if (dut.shift_q !== 8'h00) begin
            errors++;
            $display("FAIL reset_state edge%0d: got %h want 00", k, dut.shift_q);
         end
      end
   endtask

   // Load a word, then shift for `total` bit positions checking each one.
   task automatic serialize(input string name, input logic [W-1:0] word, input int unsigned total);
      reset = 1'b0; load = 1'b1; parallel_in = word;
      step();
      load = 1'b0; parallel_in = ~word;
      for (int unsigned i = 0; i < total; i++) begin
         if (i != 0) step();
         checks++;
         if (serial_out !== exp_bit(word, i)) begin
            errors++;
            $display("FAIL %s word=%h bit%0d: got %b want %b", name, word, i, serial_out, exp_bit(word, i));
         end
      end
   endtask

   task automatic test_basic();
      serialize("basic", 8'hA5, W + 4);
   endtask

   task automatic test_reset_priority();
      serialize("prio_pre", 8'h3C, 2);
      reset = 1'b1; load = 1'b1; parallel_in = 8'hFF;
      step();
      checks++;
      if (serial_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_over_load: got %b want 0", serial_out);
      end
      checks++;
      if (dut.shift_q !== 8'h00) begin
         errors++;
         $display("FAIL reset_over_load_state: got %h want 00", dut.shift_q);
      end
      reset = 1'b0; load = 1'b0;
   endtask

   task automatic test_reload();
      serialize("reload_old", 8'hF0, 4);
      serialize("reload_new", 8'h0F, W + 2);
   endtask

   task automatic test_reset_mid();
      serialize("rst_mid_pre", 8'hFF, 3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < W + 1; k++) begin
         checks++;
         if (serial_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cyc%0d: got %b want 0", k, serial_out);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] words [3];
      words[0] = 8'h81; words[1] = 8'h3C; words[2] = 8'hC3;
      reset = 1'b0; load = 1'b1;
      for (int k = 0; k < 3; k++) begin
         parallel_in = words[k];
         step();
         checks++;
         if (serial_out !== exp_bit(words[k], 0)) begin
            errors++;
            $display("FAIL held_load word=%h: got %b want %b", words[k], serial_out, exp_bit(words[k], 0));
         end
      end
      load = 1'b0;
      for (int unsigned i = 1; i < W + 2; i++) begin
         step();
         checks++;
         if (serial_out !== exp_bit(words[2], i)) begin
            errors++;
            $display("FAIL held_tail bit%0d: got %b want %b", i, serial_out, exp_bit(words[2], i));
         end
      end
   endtask

   task automatic test_bit_order();
      serialize("order_a5", 8'hA5, W);
      serialize("order_01", 8'h01, W + 2);
      serialize("order_80", 8'h80, W + 2);
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; parallel_in = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_reset_priority();
      test_reload();
      test_reset_mid();
      test_back_to_back();
      test_bit_order();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
